// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_pkg
// Purpose  : Shared definitions for the tick scheduler: prescaler divide
//            computation, channel-index width helper and config FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package tick_pkg;

    // Config FSM encoding: IDLE accepts a request, APPLY writes it to a channel.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } cfg_state_t;

    // Number of clk cycles per base tick.
    function automatic int calc_div(input int clk_hz, input int base_hz);
        return clk_hz / base_hz;
    endfunction

    // Channel select width; a single-channel build still gets a 1-bit select.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage : tick_pkg
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// ============================================================================
// Module   : tick_channel
// Purpose  : One scheduler channel: divides the shared base tick by a
//            programmable period and emits a registered one-cycle tick.
//            A config write clears the counter and suppresses that cycle's
//            tick; a decrement request shortens the period with a floor.
// Revision : 1.0 - initial release
// ============================================================================
module tick_channel #(
    parameter int PER_W          = 16,
    parameter int DEFAULT_PERIOD = 100,
    parameter int DEC_STEP       = 1,
    parameter int DEC_MIN        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_base_tick,
    input  logic             i_wr,
    input  logic [PER_W-1:0] i_wr_period,
    input  logic             i_wr_en,
    input  logic             i_dec,
    output logic             o_tick,
    output logic             o_active
);

    localparam logic [PER_W-1:0] c_one     = PER_W'(1);
    localparam logic [PER_W-1:0] c_def     = (DEFAULT_PERIOD == 0) ? c_one : PER_W'(DEFAULT_PERIOD);
    localparam logic [PER_W-1:0] c_step    = PER_W'(DEC_STEP);
    localparam logic [PER_W-1:0] c_min     = PER_W'(DEC_MIN);
    localparam logic [PER_W:0]   c_one_x   = (PER_W+1)'(1);
    localparam logic [PER_W:0]   c_floor_x = (PER_W+1)'(DEC_STEP) + (PER_W+1)'(DEC_MIN);

    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_period;
    logic             r_en;
    logic             r_tick;
    logic             w_hit;
    logic [PER_W-1:0] w_dec_period;

    // Rollover when cnt >= period-1, computed one bit wider so it never underflows.
    assign w_hit        = ({1'b0, r_cnt} + c_one_x) >= {1'b0, r_period};
    // Saturating decrement: max(period - step, floor).
    assign w_dec_period = ({1'b0, r_period} >= c_floor_x) ? (r_period - c_step) : c_min;

    // Counter, period, enable and tick register; a config write overrides everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_period <= c_def;
            r_en     <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_wr) begin
                r_period <= i_wr_period;
                r_en     <= i_wr_en;
                r_cnt    <= '0;
            end else begin
                if (i_dec) begin
                    r_period <= w_dec_period;
                end
                if (i_base_tick && r_en) begin
                    if (w_hit) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
            end
        end
    end

    assign o_tick   = r_tick;
    assign o_active = r_en;

endmodule : tick_channel
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tick_scheduler
// Purpose  : Central game-timing scheduler. A shared prescaler produces the
//            base tick; NUM_CH tick_channel instances divide it into
//            per-channel pulses. Periods/enables are written through a
//            valid/ready config port served by a two-state FSM.
//            Optional feature macro: TICK_SCHED_SPEEDUP_EN adds a speedup
//            pulse input that shortens channel 0's period.
// Revision : 1.0 - initial release
// ============================================================================
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int BASE_HZ        = 1000,
    parameter int NUM_CH         = 4,
    parameter int PER_W          = 16,
    parameter int DEFAULT_PERIOD = 100,
    parameter int SPEED_STEP     = 1,
    parameter int MIN_PERIOD     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pause,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0]    cfg_ch,
    input  logic [PER_W-1:0]               cfg_period,
    input  logic                           cfg_en,
`ifdef TICK_SCHED_SPEEDUP_EN
    input  logic                           speedup,
`endif
    output logic                           base_tick,
    output logic [NUM_CH-1:0]              ch_tick,
    output logic [NUM_CH-1:0]              ch_active
);

    localparam int               c_div   = calc_div(CLK_HZ, BASE_HZ);
    localparam int               c_pre_w = $clog2(c_div);
    localparam int               c_ch_w  = ch_idx_w(NUM_CH);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(c_div - 1);
    localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);
    localparam logic [PER_W-1:0]   c_per_one  = PER_W'(1);

    logic [c_pre_w-1:0] r_presc;
    logic               r_base_tick;

    cfg_state_t         r_state;
    cfg_state_t         w_state_nxt;
    logic               r_cfg_ready;
    logic               w_accept;
    logic [c_ch_w-1:0]  r_cfg_ch;
    logic [PER_W-1:0]   r_cfg_period;
    logic               r_cfg_en;

    logic [NUM_CH-1:0]  w_dec;

    // Prescaler: count 0..DIV-1, pulse base_tick the cycle after the terminal count; pause freezes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_base_tick <= 1'b0;
        end else if (pause) begin
            r_base_tick <= 1'b0;
        end else if (r_presc == c_pre_last) begin
            r_presc     <= '0;
            r_base_tick <= 1'b1;
        end else begin
            r_presc     <= r_presc + c_pre_one;
            r_base_tick <= 1'b0;
        end
    end

    assign w_accept = cfg_valid && r_cfg_ready;

    // Config FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Config FSM next state: every accept is followed by exactly one APPLY cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_APPLY;
            ST_APPLY: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered ready (low through reset) and request capture; period 0 is stored as 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg_ready  <= 1'b0;
            r_cfg_ch     <= '0;
            r_cfg_period <= c_per_one;
            r_cfg_en     <= 1'b0;
        end else begin
            r_cfg_ready <= (w_state_nxt == ST_IDLE);
            if (w_accept) begin
                r_cfg_ch     <= cfg_ch;
                r_cfg_period <= (cfg_period == '0) ? c_per_one : cfg_period;
                r_cfg_en     <= cfg_en;
            end
        end
    end

`ifdef TICK_SCHED_SPEEDUP_EN
    // Speedup only ever targets channel 0.
    always_comb begin
        w_dec    = '0;
        w_dec[0] = speedup;
    end
`else
    assign w_dec = '0;
`endif

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic w_wr;
            // Out-of-range channel selects match no instance, so the write is dropped.
            assign w_wr = (r_state == ST_APPLY) && (r_cfg_ch == c_ch_w'(i));

            tick_channel #(
                .PER_W          (PER_W),
                .DEFAULT_PERIOD (DEFAULT_PERIOD),
                .DEC_STEP       (SPEED_STEP),
                .DEC_MIN        (MIN_PERIOD)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_base_tick (r_base_tick),
                .i_wr        (w_wr),
                .i_wr_period (r_cfg_period),
                .i_wr_en     (r_cfg_en),
                .i_dec       (w_dec[i]),
                .o_tick      (ch_tick[i]),
                .o_active    (ch_active[i])
            );
        end
    endgenerate

    assign base_tick = r_base_tick;
    assign cfg_ready = r_cfg_ready;

endmodule : tick_scheduler
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_scheduler
// Purpose  : Directed self-checking bench for tick_scheduler
//            (DIV=10, NUM_CH=4, DEFAULT_PERIOD=5), plus a NUM_CH=3 instance
//            for the out-of-range channel write. Speedup steps run when
//            TICK_SCHED_SPEEDUP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    logic        clk;
    logic        rst_n;
    logic        pause;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_en;
    logic        speedup;
    logic        base_tick;
    logic [3:0]  ch_tick;
    logic [3:0]  ch_active;

    logic        v3;
    logic        rdy3;
    logic [1:0]  ch3;
    logic [15:0] per3;
    logic        en3;
    logic        bt3;
    logic [2:0]  tick3;
    logic [2:0]  act3;

    int vec_cnt;
    int err_cnt;
    int e;

    tick_scheduler #(
        .CLK_HZ(1000), .BASE_HZ(100), .NUM_CH(4), .PER_W(16),
        .DEFAULT_PERIOD(5), .SPEED_STEP(2), .MIN_PERIOD(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_en(cfg_en),
`ifdef TICK_SCHED_SPEEDUP_EN
        .speedup(speedup),
`endif
        .base_tick(base_tick), .ch_tick(ch_tick), .ch_active(ch_active)
    );

    tick_scheduler #(
        .CLK_HZ(1000), .BASE_HZ(100), .NUM_CH(3), .PER_W(16),
        .DEFAULT_PERIOD(5), .SPEED_STEP(2), .MIN_PERIOD(2)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .pause(1'b0),
        .cfg_valid(v3), .cfg_ready(rdy3), .cfg_ch(ch3),
        .cfg_period(per3), .cfg_en(en3),
`ifdef TICK_SCHED_SPEEDUP_EN
        .speedup(1'b0),
`endif
        .base_tick(bt3), .ch_tick(tick3), .ch_active(act3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    task automatic goto_edge(input int t);
        if (t > e) step(t - e);
    endtask

    // Accept on the next edge, APPLY on the one after.
    task automatic cfg(input logic [1:0] ch, input logic [15:0] per, input logic en);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_period = per;
        cfg_en     = en;
        step(1);
        chk("cfg_ready_low_in_apply", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        step(1);
        chk("cfg_ready_back", {31'd0, cfg_ready}, 32'd1);
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0; e = 0;
        rst_n = 1'b0; pause = 1'b0; speedup = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_period = 16'd0; cfg_en = 1'b0;
        v3 = 1'b0; ch3 = 2'd0; per3 = 16'd0; en3 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_base_tick", {31'd0, base_tick}, 32'd0);
        chk("rst_ch_tick",   {28'd0, ch_tick},   32'd0);
        chk("rst_ch_active", {28'd0, ch_active}, 32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        rst_n = 1'b1;
        e = 0;

        // Release and base-tick cadence
        step(1);
        chk("ready_after_release", {31'd0, cfg_ready}, 32'd1);
        goto_edge(9);
        chk("no_base_tick_early", {31'd0, base_tick}, 32'd0);
        goto_edge(10);
        chk("first_base_tick", {31'd0, base_tick}, 32'd1);
        chk("no_ch_tick_disabled", {28'd0, ch_tick}, 32'd0);
        goto_edge(11);
        chk("base_tick_one_wide", {31'd0, base_tick}, 32'd0);
        goto_edge(20);
        chk("second_base_tick", {31'd0, base_tick}, 32'd1);

        // ch1 period 3
        cfg(2'd1, 16'd3, 1'b1);
        chk("ch_active_ch1", {28'd0, ch_active}, 32'h2);
        goto_edge(50);
        chk("base_before_ch1", {31'd0, base_tick}, 32'd1);
        chk("ch1_not_yet", {28'd0, ch_tick}, 32'd0);
        goto_edge(51);
        chk("ch1_tick_1", {28'd0, ch_tick}, 32'h2);
        goto_edge(52);
        chk("ch1_tick_one_wide", {28'd0, ch_tick}, 32'd0);
        goto_edge(81);
        chk("ch1_tick_2", {28'd0, ch_tick}, 32'h2);

        // cfg_valid held 4 clk: ch0 then ch2
        goto_edge(82);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd4; cfg_en = 1'b1;
        step(1);
        chk("hold_accept0_ready", {31'd0, cfg_ready}, 32'd0);
        cfg_ch = 2'd2; cfg_period = 16'd6;
        step(1);
        chk("hold_apply0_ready", {31'd0, cfg_ready}, 32'd1);
        chk("hold_apply0_active", {28'd0, ch_active}, 32'h3);
        step(1);
        chk("hold_accept2_ready", {31'd0, cfg_ready}, 32'd0);
        chk("hold_accept2_active", {28'd0, ch_active}, 32'h3);
        step(1);
        cfg_valid = 1'b0;
        chk("hold_apply2_ready", {31'd0, cfg_ready}, 32'd1);
        chk("hold_apply2_active", {28'd0, ch_active}, 32'h7);
        goto_edge(121);
        chk("ch0_period4_tick", {28'd0, ch_tick}, 32'h1);
        goto_edge(141);
        chk("ch1_ch2_tick", {28'd0, ch_tick}, 32'h6);

        // Out-of-range channel on the NUM_CH=3 instance
        v3 = 1'b1; ch3 = 2'd3; per3 = 16'd2; en3 = 1'b1;
        step(1);
        chk("oor_ready_low", {31'd0, rdy3}, 32'd0);
        v3 = 1'b0;
        step(1);
        chk("oor_ready_back", {31'd0, rdy3}, 32'd1);
        chk("oor_no_write", {29'd0, act3}, 32'd0);

        // Pause 25 clk with ch0 period 2
        cfg(2'd0, 16'd2, 1'b1);
        goto_edge(161);
        chk("ch0_p2_tick", {31'd0, ch_tick[0]}, 32'd1);
        goto_edge(162);
        pause = 1'b1;
        goto_edge(170);
        chk("pause_no_base", {31'd0, base_tick}, 32'd0);
        goto_edge(171);
        chk("pause_no_ch0", {31'd0, ch_tick[0]}, 32'd0);
        goto_edge(187);
        pause = 1'b0;
        goto_edge(194);
        chk("resume_not_yet", {31'd0, base_tick}, 32'd0);
        goto_edge(195);
        chk("resume_base_shifted", {31'd0, base_tick}, 32'd1);
        goto_edge(196);
        chk("resume_ch0_count", {31'd0, ch_tick[0]}, 32'd0);
        goto_edge(205);
        chk("resume_base_2", {31'd0, base_tick}, 32'd1);
        goto_edge(206);
        chk("resume_ch0_tick", {31'd0, ch_tick[0]}, 32'd1);

        // Period 0 -> every base tick; APPLY on rollover suppresses tick
        cfg(2'd3, 16'd0, 1'b1);
        goto_edge(216);
        chk("p0_tick_1", {31'd0, ch_tick[3]}, 32'd1);
        goto_edge(217);
        chk("p0_tick_gap", {31'd0, ch_tick[3]}, 32'd0);
        goto_edge(226);
        chk("p0_tick_2", {31'd0, ch_tick[3]}, 32'd1);
        goto_edge(234);
        cfg(2'd3, 16'd2, 1'b1);
        chk("apply_wins_rollover", {31'd0, ch_tick[3]}, 32'd0);
        goto_edge(246);
        chk("apply_cnt_cleared", {31'd0, ch_tick[3]}, 32'd0);
        goto_edge(256);
        chk("apply_new_period", {31'd0, ch_tick[3]}, 32'd1);

`ifdef TICK_SCHED_SPEEDUP_EN
        // Speedup: 5 -> 3 -> 2 -> 2
        cfg(2'd0, 16'd5, 1'b1);
        speedup = 1'b1;
        step(1);
        speedup = 1'b0;
        goto_edge(276);
        chk("sp_p3_count", {31'd0, ch_tick[0]}, 32'd0);
        goto_edge(286);
        chk("sp_p3_tick", {31'd0, ch_tick[0]}, 32'd1);
        speedup = 1'b1;
        step(1);
        speedup = 1'b0;
        step(1);
        speedup = 1'b1;
        step(1);
        speedup = 1'b0;
        goto_edge(296);
        chk("sp_floor_no_p1", {31'd0, ch_tick[0]}, 32'd0);
        goto_edge(306);
        chk("sp_p2_tick_1", {31'd0, ch_tick[0]}, 32'd1);
        goto_edge(316);
        chk("sp_p2_gap", {31'd0, ch_tick[0]}, 32'd0);
        goto_edge(326);
        chk("sp_p2_tick_2", {31'd0, ch_tick[0]}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_tick_scheduler
`default_nettype wire
